debounce_tick: RTL and testbench

//  Upstream stage of the toggle data register: turns a raw, bouncing push-button

---
 rtl/debounce_tick_if.sv | 9 +
 rtl/debounce_tick.sv | 127 ++++++++++++
 tb/tb_debounce_tick.sv | 128 ++++++++++++
 3 files changed

// File: rtl/debounce_tick_if.sv
// Button-side bus of debounce_tick: raw button in, debounced level and press tick out.
interface debounce_tick_if;
   logic btn;
   logic db_level;
   logic tg_tick;

   modport master (output btn, input db_level, input tg_tick);
   modport slave  (input btn, output db_level, output tg_tick);
endinterface

// File: rtl/debounce_tick.sv
// Push-button debouncer: 2-FF synchronizer, 4-state debounce FSM, one-cycle tick per press.
// Optional auto-repeat while held is enabled by defining DEBOUNCE_TICK_REPEAT_EN.
module debounce_tick #(
   parameter int unsigned DB_CYCLES     = 500000,
   parameter int unsigned CNT_WIDTH     = 20,
   parameter int unsigned REPEAT_CYCLES = 12500000,
   parameter int unsigned RPT_WIDTH     = 24
) (
   input  logic            clk,
   input  logic            rst,
   debounce_tick_if.slave  bus
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DB_CYCLES - 1);

   typedef enum logic [1:0] {
      ZERO  = 2'd0,
      WAIT1 = 2'd1,
      ONE   = 2'd2,
      WAIT0 = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 s1_q, s2_q;
   logic                 lvl_q, lvl_d;
   logic                 tick_q, tick_d;

`ifdef DEBOUNCE_TICK_REPEAT_EN
   localparam logic [RPT_WIDTH-1:0] RPT_MAX = RPT_WIDTH'(REPEAT_CYCLES - 1);
   logic [RPT_WIDTH-1:0] rpt_q, rpt_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rpt_q <= '0;
      else      rpt_q <= rpt_d;
   end
`endif

   // Synchronizer; the FSM only ever looks at s2_q
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= bus.btn;
         s2_q <= s1_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ZERO;
         cnt_q   <= '0;
         lvl_q   <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lvl_q   <= lvl_d;
         tick_q  <= tick_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tick_d  = 1'b0;

      unique case (state_q)
         ZERO: begin
            if (s2_q) begin
               state_d = WAIT1;
               cnt_d   = '0;
            end
         end
         WAIT1: begin
            if (!s2_q) begin
               state_d = ZERO;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = ONE;
               tick_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
         ONE: begin
            if (!s2_q) begin
               state_d = WAIT0;
               cnt_d   = '0;
            end
         end
         WAIT0: begin
            if (s2_q) begin
               state_d = ONE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = ZERO;
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
         default: begin
            state_d = ZERO;
            cnt_d   = '0;
         end
      endcase

`ifdef DEBOUNCE_TICK_REPEAT_EN
      // Repeat counter runs only while settled in ONE; the cycle after any tick holds it at 0
      rpt_d = '0;
      if (state_q == ONE && state_d == ONE && !tick_q) begin
         if (rpt_q == RPT_MAX) begin
            tick_d = 1'b1;
         end else begin
            rpt_d = rpt_q + RPT_WIDTH'(1);
         end
      end
`endif

      lvl_d = (state_d == ONE) || (state_d == WAIT0);
   end

   assign bus.db_level = lvl_q;
   assign bus.tg_tick  = tick_q;

endmodule

// File: tb/tb_debounce_tick.sv
// Directed bench for debounce_tick with DB_CYCLES=4, REPEAT_CYCLES=8.
module tb_debounce_tick;

   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   debounce_tick_if bus ();

   debounce_tick #(
      .DB_CYCLES    (4),
      .CNT_WIDTH    (3),
      .REPEAT_CYCLES(8),
      .RPT_WIDTH    (4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int e, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s edge=%0d observed=%b expected=%b", tag, e, obs, exp);
      end
   endtask

   // Step n edges; tick expected only at edges t1/t2/t3, level flips from lvl0 at lvl_edge
   task automatic run(input string tag, input int n, input logic lvl0, input int lvl_edge,
                      input int t1, input int t2, input int t3);
      logic exp_lvl;
      logic exp_tick;
      for (int e = 1; e <= n; e++) begin
         @(posedge clk);
         #1;
         exp_tick = (e == t1) || (e == t2) || (e == t3);
         exp_lvl  = (lvl_edge != 0 && e >= lvl_edge) ? ~lvl0 : lvl0;
         check({tag, "_tick"}, e, bus.tg_tick, exp_tick);
         check({tag, "_lvl"},  e, bus.db_level, exp_lvl);
      end
   endtask

   initial begin
      rst     = 1'b0;
      bus.btn = 1'b0;

      // 1. reset held while btn toggles
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         bus.btn = ~bus.btn;
         @(posedge clk);
         #1;
         check("rst_tick", i, bus.tg_tick, 1'b0);
         check("rst_lvl",  i, bus.db_level, 1'b0);
      end
      @(negedge clk);
      bus.btn = 1'b0;
      rst     = 1'b1;
      run("idle", 4, 1'b0, 0, 0, 0, 0);

      // 2. clean press
      @(negedge clk);
      bus.btn = 1'b1;
      run("press", 10, 1'b0, 7, 7, 0, 0);

      // 4a. clean release never ticks
      @(negedge clk);
      bus.btn = 1'b0;
      run("release", 10, 1'b1, 7, 0, 0, 0);

      // 3. bounce: two high cycles, low, then held high
      @(negedge clk);
      bus.btn = 1'b1;
      run("bounce_hi", 2, 1'b0, 0, 0, 0, 0);
      @(negedge clk);
      bus.btn = 1'b0;
      run("bounce_lo", 4, 1'b0, 0, 0, 0, 0);
      @(negedge clk);
      bus.btn = 1'b1;
      run("bounce_press", 10, 1'b0, 7, 7, 0, 0);

      // 4b. 2-cycle low glitch while held
      @(negedge clk);
      bus.btn = 1'b0;
      run("glitch_lo", 2, 1'b1, 0, 0, 0, 0);
      @(negedge clk);
      bus.btn = 1'b1;
      run("glitch_hi", 6, 1'b1, 0, 0, 0, 0);

      // 5. reset mid-WAIT1 at cnt=2, then restart with btn still high
      @(negedge clk);
      bus.btn = 1'b0;
      run("rel2", 8, 1'b1, 7, 0, 0, 0);
      @(negedge clk);
      bus.btn = 1'b1;
      run("pre_rst", 5, 1'b0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_tick", 0, bus.tg_tick, 1'b0);
      check("midrst_lvl",  0, bus.db_level, 1'b0);
      run("in_rst", 2, 1'b0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      run("post_rst", 10, 1'b0, 7, 7, 0, 0);

      // 6. long hold: auto-repeat ticks only when enabled
      @(negedge clk);
      bus.btn = 1'b0;
      run("rel3", 8, 1'b1, 7, 0, 0, 0);
      @(negedge clk);
      bus.btn = 1'b1;
`ifdef DEBOUNCE_TICK_REPEAT_EN
      run("hold", 30, 1'b0, 7, 7, 16, 25);
`else
      run("hold", 30, 1'b0, 7, 7, 0, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
